// File: rtl/arbitro_transaccion.sv
// Round-robin mover from 4 input FIFOs to 4 output FIFOs by destination field; optional per-output push counters under ARB_COUNTERS_EN.
// Latency: pop_in combinational, push_out/data_out registered one cycle after the pop; 1 word/cycle sustained across inputs.
// Backpressure: requesters whose destination FIFO is almost full are masked; init=1 suppresses grants and returns to INIT.
module arbitro_transaccion #(
   parameter int FIFO_WORD_SIZE = 10,
   parameter int FIFO_PTR_SIZE  = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      init,
   input  logic [FIFO_PTR_SIZE-1:0]  almost_empty_threshold_input,
   input  logic [FIFO_PTR_SIZE-1:0]  almost_full_threshold_input,
   input  logic [3:0]                fifo_in_empty,
   input  logic [FIFO_WORD_SIZE-1:0] data_in0,
   input  logic [FIFO_WORD_SIZE-1:0] data_in1,
   input  logic [FIFO_WORD_SIZE-1:0] data_in2,
   input  logic [FIFO_WORD_SIZE-1:0] data_in3,
   input  logic [3:0]                fifo_out_almost_full,
`ifdef ARB_COUNTERS_EN
   input  logic                      req,
   input  logic [1:0]                idx,
   output logic [4:0]                count_data,
   output logic                      count_valid,
`endif
   output logic [3:0]                pop_in,
   output logic [3:0]                push_out,
   output logic [FIFO_WORD_SIZE-1:0] data_out,
   output logic [FIFO_PTR_SIZE-1:0]  almost_empty_threshold,
   output logic [FIFO_PTR_SIZE-1:0]  almost_full_threshold,
   output logic [1:0]                grant_idx,
   output logic [1:0]                state,
   output logic                      idle
);

   typedef enum logic [1:0] {
      ST_RESET  = 2'd0,
      ST_INIT   = 2'd1,
      ST_IDLE   = 2'd2,
      ST_ACTIVE = 2'd3
   } state_t;

   state_t                    state_q, state_d;
   logic [FIFO_PTR_SIZE-1:0]  ae_thr_q, ae_thr_d;
   logic [FIFO_PTR_SIZE-1:0]  af_thr_q, af_thr_d;
   logic [3:0]                push_out_q, push_out_d;
   logic [FIFO_WORD_SIZE-1:0] data_out_q, data_out_d;
   logic [1:0]                grant_idx_q, grant_idx_d;
   logic [1:0]                rr_ptr_q, rr_ptr_d;

   logic [FIFO_WORD_SIZE-1:0] din [4];
   logic [3:0]                cand;
   logic                      grant_vld;
   logic [1:0]                grant;
   logic [1:0]                cidx;
   logic                      do_grant;
   logic [1:0]                grant_dest;

   assign din[0] = data_in0;
   assign din[1] = data_in1;
   assign din[2] = data_in2;
   assign din[3] = data_in3;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         cand[i] = !fifo_in_empty[i] && !fifo_out_almost_full[din[i][FIFO_WORD_SIZE-1 -: 2]];
      end
   end

   // Search starts one past the last grant, so the last winner has lowest priority.
   always_comb begin
      grant_vld = 1'b0;
      grant     = rr_ptr_q;
      cidx      = rr_ptr_q;
      for (int k = 1; k <= 4; k++) begin
         cidx = rr_ptr_q + 2'(k);
         if (!grant_vld && cand[cidx]) begin
            grant_vld = 1'b1;
            grant     = cidx;
         end
      end
   end

   assign do_grant   = (state_q == ST_ACTIVE) && !init && grant_vld;
   assign pop_in     = do_grant ? (4'b0001 << grant) : 4'b0000;
   assign grant_dest = din[grant][FIFO_WORD_SIZE-1 -: 2];

   always_comb begin
      state_d     = state_q;
      ae_thr_d    = ae_thr_q;
      af_thr_d    = af_thr_q;
      push_out_d  = 4'b0000;
      data_out_d  = data_out_q;
      grant_idx_d = grant_idx_q;
      rr_ptr_d    = rr_ptr_q;
      case (state_q)
         ST_RESET: state_d = ST_INIT;
         ST_INIT: begin
            ae_thr_d = almost_empty_threshold_input;
            af_thr_d = almost_full_threshold_input;
            if (!init) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (init)                    state_d = ST_INIT;
            else if (|(~fifo_in_empty))  state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            // Leave as soon as nothing is left besides the word being popped now,
            // so the final push lands in the IDLE cycle.
            if (init)                                        state_d = ST_INIT;
            else if ((~fifo_in_empty & ~pop_in) == 4'b0000)  state_d = ST_IDLE;
         end
         default: state_d = ST_RESET;
      endcase
      if (do_grant) begin
         data_out_d  = din[grant];
         push_out_d  = 4'b0001 << grant_dest;
         grant_idx_d = grant;
         rr_ptr_d    = grant;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_RESET;
         ae_thr_q    <= '0;
         af_thr_q    <= '0;
         push_out_q  <= 4'b0000;
         data_out_q  <= '0;
         grant_idx_q <= 2'd0;
         rr_ptr_q    <= 2'd3;
      end else begin
         state_q     <= state_d;
         ae_thr_q    <= ae_thr_d;
         af_thr_q    <= af_thr_d;
         push_out_q  <= push_out_d;
         data_out_q  <= data_out_d;
         grant_idx_q <= grant_idx_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign push_out               = push_out_q;
   assign data_out               = data_out_q;
   assign almost_empty_threshold = ae_thr_q;
   assign almost_full_threshold  = af_thr_q;
   assign grant_idx              = grant_idx_q;
   assign state                  = state_q;
   assign idle                   = (state_q == ST_IDLE);

`ifdef ARB_COUNTERS_EN
   logic [4:0] cnt_q [4];
   logic [4:0] cnt_d [4];
   logic [4:0] count_data_q, count_data_d;
   logic       count_valid_q, count_valid_d;
   logic       init_entry;

   assign init_entry = (state_d == ST_INIT) && (state_q != ST_INIT);

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = cnt_q[i];
         if (init_entry)                               cnt_d[i] = 5'd0;
         else if (push_out_q[i] && cnt_q[i] != 5'd31)  cnt_d[i] = cnt_q[i] + 5'd1;
      end
      count_valid_d = (state_q == ST_IDLE) && req;
      count_data_d  = count_valid_d ? cnt_q[idx] : count_data_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) cnt_q[i] <= 5'd0;
         count_data_q  <= 5'd0;
         count_valid_q <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
         count_data_q  <= count_data_d;
         count_valid_q <= count_valid_d;
      end
   end

   assign count_data  = count_data_q;
   assign count_valid = count_valid_q;
`endif

endmodule

// File: tb/tb_arbitro_transaccion.sv
// Scoreboard bench for arbitro_transaccion: queue-modelled input FIFOs, expected pushes queued by the
// stimulus and consumed by an independent monitor whenever push_out is non-zero.
module tb_arbitro_transaccion;
   logic       clk = 1'b0;
   logic       reset;
   logic       init;
   logic [2:0] ae_in, af_in;
   logic [3:0] fifo_in_empty;
   logic [3:0] af_flags;
   logic [9:0] din_tb [4];
   logic [3:0] pop_in, push_out;
   logic [9:0] data_out;
   logic [2:0] ae_thr, af_thr;
   logic [1:0] grant_idx, state;
   logic       idle;
`ifdef ARB_COUNTERS_EN
   logic       req;
   logic [1:0] idx;
   logic [4:0] count_data;
   logic       count_valid;
`endif

   arbitro_transaccion #(.FIFO_WORD_SIZE(10), .FIFO_PTR_SIZE(3)) dut (
      .clk                          (clk),
      .reset                        (reset),
      .init                         (init),
      .almost_empty_threshold_input (ae_in),
      .almost_full_threshold_input  (af_in),
      .fifo_in_empty                (fifo_in_empty),
      .data_in0                     (din_tb[0]),
      .data_in1                     (din_tb[1]),
      .data_in2                     (din_tb[2]),
      .data_in3                     (din_tb[3]),
      .fifo_out_almost_full         (af_flags),
`ifdef ARB_COUNTERS_EN
      .req                          (req),
      .idx                          (idx),
      .count_data                   (count_data),
      .count_valid                  (count_valid),
`endif
      .pop_in                       (pop_in),
      .push_out                     (push_out),
      .data_out                     (data_out),
      .almost_empty_threshold       (ae_thr),
      .almost_full_threshold        (af_thr),
      .grant_idx                    (grant_idx),
      .state                        (state),
      .idle                         (idle)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] push;
      logic [9:0] data;
   } exp_t;

   exp_t       exp_q [$];
   logic [9:0] inq [4][$];
   logic [3:0] pop_s = 4'b0000;
   int         n_chk = 0;
   int         n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   task automatic refresh();
      for (int i = 0; i < 4; i++) begin
         fifo_in_empty[i] = (inq[i].size() == 0);
         din_tb[i]        = (inq[i].size() != 0) ? inq[i][0] : 10'h000;
      end
   endtask

   task automatic load(input int i, input logic [9:0] w);
      inq[i].push_back(w);
      refresh();
   endtask

   task automatic expect_push(input logic [3:0] p, input logic [9:0] d);
      exp_t e;
      e.push = p;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_state(input logic [1:0] st, input int max, input string name);
      bit ok = 1'b0;
      for (int i = 0; i < max && !ok; i++) begin
         @(negedge clk);
         if (state == st) ok = 1'b1;
      end
      chk(name, state, st);
   endtask

   task automatic wait_pop(input logic [3:0] p, input int max, input string name);
      bit ok = 1'b0;
      for (int i = 0; i < max && !ok; i++) begin
         @(negedge clk);
         if (pop_in == p) ok = 1'b1;
      end
      chk(name, pop_in, p);
   endtask

   task automatic wait_drained(input int max, input string name);
      bit ok = 1'b0;
      for (int i = 0; i < max && !ok; i++) begin
         @(negedge clk);
         if (state == 2'd2 && push_out == 4'b0000 && exp_q.size() == 0 &&
             inq[0].size() == 0 && inq[1].size() == 0 && inq[2].size() == 0 && inq[3].size() == 0)
            ok = 1'b1;
      end
      chk(name, ok, 1);
   endtask

   // Input FIFO model: a pop seen before the edge removes the head just after it.
   always @(negedge clk) pop_s = pop_in;
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < 4; i++)
         if (pop_s[i] && inq[i].size() != 0) void'(inq[i].pop_front());
      refresh();
   end

   // Monitor: every presented push must match the next expected word.
   always @(negedge clk) begin
      if (push_out !== 4'b0000) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_push: got push_out=%b data_out=0x%0h, want no push", push_out, data_out);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("push_out", push_out, e.push);
            chk("data_out", data_out, e.data);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_chk);
      $fatal(1);
   end

   initial begin
      logic [3:0] rr_pops [5];
      logic [3:0] bp_pops [7];
      rr_pops = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      bp_pops = '{4'b0000, 4'b0100, 4'b1000, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
      reset = 1'b1; init = 1'b1; ae_in = 3'd1; af_in = 3'd6; af_flags = 4'b0000;
`ifdef ARB_COUNTERS_EN
      req = 1'b0; idx = 2'd0;
`endif
      refresh();

      // Reset values and configuration
      @(negedge clk);
      chk("rst_state", state, 0);
      chk("rst_pop", pop_in, 0);
      chk("rst_push", push_out, 0);
      chk("rst_data", data_out, 0);
      chk("rst_ae", ae_thr, 0);
      chk("rst_af", af_thr, 0);
      chk("rst_grant", grant_idx, 0);
      chk("rst_idle", idle, 0);
      step(); reset = 1'b0;
      @(negedge clk); chk("held_reset_state", state, 0);
      @(negedge clk); chk("release_to_init", state, 1);
      step(); init = 1'b0;
      @(negedge clk); chk("init_hold", state, 1);
      @(negedge clk);
      chk("cfg_state", state, 2);
      chk("cfg_idle", idle, 1);
      chk("cfg_ae", ae_thr, 1);
      chk("cfg_af", af_thr, 6);

      // Round robin over all four inputs, destinations 3,2,1,0 then 3 again
      step();
      load(0, 10'h301); load(1, 10'h202); load(2, 10'h103); load(3, 10'h004); load(0, 10'h305);
      expect_push(4'b1000, 10'h301); expect_push(4'b0100, 10'h202);
      expect_push(4'b0010, 10'h103); expect_push(4'b0001, 10'h004);
      expect_push(4'b1000, 10'h305);
      @(negedge clk); chk("rr_idle_pop", pop_in, 0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); chk($sformatf("rr_pop%0d", k), pop_in, rr_pops[k]);
      end
      @(negedge clk);
      chk("rr_end_state", state, 2);
      chk("rr_end_grant", grant_idx, 0);

      // Output FIFO 2 almost full: input 1 (dest 2) is held, others flow
      step();
      af_flags = 4'b0100;
      load(0, 10'h011); load(0, 10'h012); load(1, 10'h211); load(2, 10'h121); load(3, 10'h331);
      expect_push(4'b0010, 10'h121); expect_push(4'b1000, 10'h331);
      expect_push(4'b0001, 10'h011); expect_push(4'b0001, 10'h012);
      for (int k = 0; k < 7; k++) begin
         @(negedge clk); chk($sformatf("bp_pop%0d", k), pop_in, bp_pops[k]);
      end
      step();
      af_flags = 4'b0000;
      expect_push(4'b0100, 10'h211);
      wait_pop(4'b0010, 4, "bp_release_pop");
      wait_drained(10, "bp_drain");

      // Single word drain: push lands while already back in IDLE
      step();
      load(2, 10'h005);
      expect_push(4'b0001, 10'h005);
      @(negedge clk); chk("drain_idle_pop", pop_in, 0);
      @(negedge clk); chk("drain_pop", pop_in, 4'b0100);
      @(negedge clk); chk("drain_push_state", state, 2);

      // init during ACTIVE: no grant, registered push completes, re-latch thresholds
      step();
      load(3, 10'h007); load(0, 10'h008);
      ae_in = 3'd2; af_in = 3'd5;
      expect_push(4'b0001, 10'h007); expect_push(4'b0001, 10'h008);
      @(negedge clk); chk("mid_idle_pop", pop_in, 0);
      @(negedge clk); chk("mid_pop", pop_in, 4'b1000);
      step(); init = 1'b1;
      @(negedge clk);
      chk("mid_init_no_grant", pop_in, 0);
      chk("mid_init_state", state, 3);
      @(negedge clk);
      chk("mid_init_entry", state, 1);
      chk("mid_init_push", push_out, 0);
      chk("mid_init_pop", pop_in, 0);
      step(); init = 1'b0;
      wait_drained(12, "mid_drain");
      chk("recfg_ae", ae_thr, 2);
      chk("recfg_af", af_thr, 5);

      // Asynchronous reset in the middle of a push cycle
      step();
      load(1, 10'h3AA);
      expect_push(4'b1000, 10'h3AA);
      @(negedge clk); chk("arst_idle_pop", pop_in, 0);
      @(negedge clk); chk("arst_pop", pop_in, 4'b0010);
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      chk("arst_push", push_out, 0);
      chk("arst_data", data_out, 0);
      chk("arst_state", state, 0);
      chk("arst_ae", ae_thr, 0);
      chk("arst_af", af_thr, 0);
      chk("arst_grant", grant_idx, 0);
      chk("arst_idle", idle, 0);
      step(); reset = 1'b0; init = 1'b1;
      wait_state(2'd1, 4, "arst_to_init");
      step(); init = 1'b0;
      wait_state(2'd2, 4, "arst_to_idle");

      // Three words to destination 1
      step();
      for (int k = 1; k <= 3; k++) begin
         load(0, 10'h100 + 10'(k));
         expect_push(4'b0010, 10'h100 + 10'(k));
      end
      wait_drained(40, "cnt3_drain");
`ifdef ARB_COUNTERS_EN
      step(); req = 1'b1; idx = 2'd1;
      @(negedge clk);
      @(negedge clk);
      chk("cnt3_valid", count_valid, 1);
      chk("cnt3_data", count_data, 3);
      step(); req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("cnt_valid_drop", count_valid, 0);
      chk("cnt_data_hold", count_data, 3);
`endif

      // Forty words to destination 0
      step();
      for (int k = 0; k < 40; k++) begin
         load(0, 10'(k));
         expect_push(4'b0001, 10'(k));
      end
      wait_drained(200, "cnt40_drain");
`ifdef ARB_COUNTERS_EN
      step(); req = 1'b1; idx = 2'd0;
      @(negedge clk);
      @(negedge clk);
      chk("cnt40_valid", count_valid, 1);
      chk("cnt40_sat", count_data, 31);
      step(); req = 1'b0;
`endif

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/arbitro_transaccion.md
Name: arbitro_transaccion

Overview:
- Round-robin scheduler that moves words from the 4 input FIFOs of the transaction layer to its 4 output FIFOs.
- Each word's destination field selects the output FIFO.
- Sequences configuration through an RESET/INIT/IDLE/ACTIVE FSM, latches and forwards the almost-empty/almost-full thresholds, and masks requesters whose destination FIFO is almost full.
- Sits between the input FIFO bank and the output FIFO bank, replacing ad-hoc push/pop generation.

Parameters:
FIFO_WORD_SIZE, 10, word width; bits [FIFO_WORD_SIZE-1:FIFO_WORD_SIZE-2] are the destination
FIFO_PTR_SIZE, 3, threshold width (log2 FIFO depth)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
init  in  1  request (re)configuration
almost_empty_threshold_input  in  FIFO_PTR_SIZE  threshold to latch in INIT
almost_full_threshold_input  in  FIFO_PTR_SIZE  threshold to latch in INIT
fifo_in_empty  in  4  empty flags of input FIFOs 0..3
data_in0..data_in3  in  FIFO_WORD_SIZE  head word of input FIFO i (first-word-fall-through)
fifo_out_almost_full  in  4  almost-full flags of output FIFOs 0..3
pop_in  out  4  one-hot pop to input FIFOs (combinational)
push_out  out  4  one-hot push to output FIFOs (registered)
data_out  out  FIFO_WORD_SIZE  word to output FIFOs (registered, shared)
almost_empty_threshold  out  FIFO_PTR_SIZE  latched config to FIFOs
almost_full_threshold  out  FIFO_PTR_SIZE  latched config to FIFOs
grant_idx  out  2  last granted input
state  out  2  RESET=0, INIT=1, IDLE=2, ACTIVE=3
idle  out  1  high when state==IDLE

Behaviour:
- reset=1 (async):
  - state=RESET; pop_in=0, push_out=0, data_out=0, thresholds=0, grant_idx=0, idle=0.
  - RR pointer=3, so the first grant goes to input 0.
  - Any in-flight push is discarded.
- RESET: goes to INIT on the first clk edge after reset falls.
- INIT:
  - Latches both threshold inputs every cycle.
  - Goes to IDLE when init=0.
  - No pops issued.
- IDLE:
  - Goes to ACTIVE if any fifo_in_empty bit is 0; otherwise stays.
  - init=1 goes to INIT; this has priority over everything except reset.
- ACTIVE:
  - Candidate i = !fifo_in_empty[i] && !fifo_out_almost_full[dest(data_in_i)].
  - Grant = first candidate searching from (grant_idx+1) mod 4 upward.
  - Grant is combinational; pop_in[g]=1 in the same cycle.
  - On the clk edge: data_out<=data_in_g, push_out<=onehot(dest), grant_idx<=g.
  - Latency pop→push is 1 cycle. Throughput is 1 word/cycle.
  - No candidate: pop_in=0, and push_out=0 on the next cycle.
  - Goes to IDLE when all inputs are empty; the registered push from the final grant still occurs in the IDLE cycle.
  - init=1 in ACTIVE: no grant that cycle, go to INIT; the already-registered push still completes.
- Head-of-line blocking is per input only; other inputs keep flowing.
- Almost-full masking uses the current flags. One word may land in an output FIFO after its flag rises, and the FIFO depth/threshold must absorb it.
- Destination decode uses the top 2 word bits; the full word is forwarded unchanged.

Optional Feature:
ARB_COUNTERS_EN:
- Defined:
  - Adds ports req (in 1), idx (in 2), count_data (out 5), count_valid (out 1).
  - One 5-bit counter per output FIFO increments on each push_out bit and saturates at 31.
  - Counters are cleared by reset and on entry to INIT.
  - req=1 in IDLE: next cycle count_valid=1, count_data=counter[idx].
  - Otherwise count_valid=0 and count_data holds its last value (0 after reset).
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
- Reset: assert reset mid-cycle while pushing → all outputs 0 immediately, state=0; release → state=1 next edge.
- Config: init=1, thresholds 1/6, then init=0 → almost_empty_threshold=1, almost_full_threshold=6, state=2, idle=1.
- Round robin: all 4 inputs non-empty, heads with dests 3,2,1,0 → pop_in 0001,0010,0100,1000,0001 on consecutive cycles; push_out 1000,0100,0010,0001 one cycle later; data_out matches the popped words.
- Backpressure: fifo_out_almost_full=0100, input1 head dest 2 → input1 never popped while others are served; clear flag → pop_in=0010 within 4 cycles.
- Drain/mid-op init: single word in input2 dest 0 → pop_in=0100, next cycle push_out=0001 with state=IDLE. Repeat with init=1 during the pop cycle → push still occurs, state=INIT.
- ARB_COUNTERS_EN: 3 words to dest 1, then in IDLE req=1 idx=1 → next cycle count_valid=1, count_data=3; 40 words to dest 0 → count_data=31.
